// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: op codes, RV32I opcode/funct3 constants and FSM states for the program-loading encoder.
package instr_encoder_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_AND, OP_LW, OP_SW, OP_BEQ, OP_HALT} op_e;
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LW     = 7'b0000011;
    localparam logic [6:0] OPC_SW     = 7'b0100011;
    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_HALT   = 7'b1111111;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational symbolic op/fields -> RV32I word, flags ops 6-7 as illegal.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    logic unused_imm0;
    assign unused_imm0 = imm[0];
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = {7'b0, rs2, rs1, F3_ADD, rd, OPC_R_TYPE};
            OP_AND:  word = {7'b0, rs2, rs1, F3_AND, rd, OPC_R_TYPE};
            OP_LW:   word = {imm[11:0], rs1, F3_LW, rd, OPC_LW};
            OP_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_SW};
            // branch offsets are halfword-aligned, so bit 0 never appears in the word
            OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BR};
            OP_HALT: word = {25'b0, OPC_HALT};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic instructions over valid/ready and writes encoded words
// sequentially into instruction memory, stopping after HALT or when memory is full.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W-2:0] count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(4 * (IMEM_WORDS - 1));

    state_e            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              illegal, acc, wr_ok, last;

    instr_pack u_pack (
        .op      (req_op),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (word),
        .illegal (illegal)
    );

    // a start pulse wins over a same-cycle handshake, which is then dropped
    assign acc   = req_valid & req_ready & ~start;
    assign wr_ok = acc & ~illegal;
    assign last  = addr == LAST_ADDR;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    always_comb begin
        req_ready = state == S_RUN;
        done      = state == S_DONE;
        state_nx  = start ? S_RUN
                  : (wr_ok && (req_op == OP_HALT || last)) ? S_DONE
                  : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            count       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else if (start) begin
            addr        <= '0;
            count       <= '0;
            wr_en       <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            wr_en <= wr_ok;
            if (wr_ok) begin
                wr_addr  <= addr;
                wr_data  <= word;
                count    <= count + 1'b1;
                // hold at the last word so the address never wraps
                addr     <= last ? addr : addr + ADDR_W'(4);
                err_full <= err_full | (last & (req_op != OP_HALT));
            end
            if (acc && illegal) err_illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven, directed and randomized checks of instr_encoder against a field-arithmetic model.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, req_valid, req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [12:0] req_imm;
    logic        wr_en, done, err_illegal, err_full;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  count;

    logic        s_start, s_valid, s_ready, s_wr_en, s_done, s_err_illegal, s_err_full;
    logic [2:0]  s_op;
    logic [3:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;

    instr_encoder #(.IMEM_WORDS(256), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
        .err_illegal(err_illegal), .err_full(err_full), .count(count)
    );

    instr_encoder #(.IMEM_WORDS(4), .ADDR_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .req_valid(s_valid), .req_ready(s_ready),
        .req_op(s_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .done(s_done),
        .err_illegal(s_err_illegal), .err_full(s_err_full), .count(s_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int op, input int rd, input int rs1, input int rs2, input logic [12:0] imm);
        req_op  = 3'(op);
        req_rd  = 5'(rd);
        req_rs1 = 5'(rs1);
        req_rs2 = 5'(rs2);
        req_imm = imm;
    endtask

    task automatic do_start();
        req_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_write(input string name, input int addr, input logic [31:0] data);
        chk({name, "_wr_en"}, wr_en, 1);
        chk({name, "_addr"}, wr_addr, addr);
        chk({name, "_data"}, wr_data, data);
    endtask

    // Reference encoder: places each RV32I field by arithmetic from the instruction-format tables.
    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int unsigned i12 = imm & 'hFFF;
        int unsigned b = imm & 'h1FFE;
        int unsigned r = (rs2 << 20) | (rs1 << 15);
        case (op)
            0: return r | (rd << 7) | 'h33;
            1: return r | (7 << 12) | (rd << 7) | 'h33;
            2: return (i12 << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            3: return ((i12 >> 5) << 25) | r | (2 << 12) | ((i12 & 31) << 7) | 'h23;
            4: return ((b >> 12) << 31) | (((b >> 5) & 63) << 25) | r | (((b >> 1) & 15) << 8)
                    | (((b >> 11) & 1) << 7) | 'h63;
            default: return 'h7F;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int nw, last_a, m_addr, m_count;
        bit m_run, m_ill, m_full, exp_we;
        logic [31:0] exp_d;
        int exp_a;

        start = 0; req_valid = 0; s_start = 0; s_valid = 0; s_op = 0;
        set_req(0, 0, 0, 0, 0);

        tbl.push_back(vec_t'{3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3});
        tbl.push_back(vec_t'{3'd1, 5'd4, 5'd1, 5'd2, 13'd0, 32'h0020F233});
        tbl.push_back(vec_t'{3'd2, 5'd5, 5'd1, 5'd6, 13'd8, 32'h0080A283});
        tbl.push_back(vec_t'{3'd3, 5'd7, 5'd1, 5'd5, 13'd12, 32'h0050A623});
        tbl.push_back(vec_t'{3'd4, 5'd9, 5'd1, 5'd2, 13'd8, 32'h00208463});
        tbl.push_back(vec_t'{3'd0, 5'd31, 5'd31, 5'd31, 13'd0, 32'h01FF8FB3});
        tbl.push_back(vec_t'{3'd2, 5'd1, 5'd2, 5'd0, 13'h1FFC, 32'hFFC12083});
        tbl.push_back(vec_t'{3'd3, 5'd0, 5'd2, 5'd3, 13'h1FF8, 32'hFE312C23});
        tbl.push_back(vec_t'{3'd4, 5'd0, 5'd0, 5'd0, 13'h1FFD, 32'hFE000EE3});

        // reset state
        repeat (2) step();
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_err_full", err_full, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", req_ready, 0);

        // table of single requests with gaps
        do_start();
        chk("run_ready", req_ready, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            set_req(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            chk_write($sformatf("tbl%0d", i), 4 * i, tbl[i].exp);
            chk($sformatf("tbl%0d_count", i), count, i + 1);
            step();
            chk($sformatf("tbl%0d_idle_wr_en", i), wr_en, 0);
        end

        // back-to-back AND, LW
        do_start();
        set_req(1, 4, 1, 2, 0); req_valid = 1'b1;
        step();
        chk_write("b2b_and", 0, 32'h0020F233);
        set_req(2, 5, 1, 0, 8);
        step();
        chk_write("b2b_lw", 4, 32'h0080A283);
        req_valid = 1'b0;
        step();
        chk("b2b_gap_wr_en", wr_en, 0);
        chk("b2b_count", count, 2);

        // SW, BEQ, HALT back-to-back
        do_start();
        set_req(3, 0, 1, 5, 12); req_valid = 1'b1;
        step();
        chk_write("seq_sw", 0, 32'h0050A623);
        set_req(4, 0, 1, 2, 8);
        step();
        chk_write("seq_beq", 4, 32'h00208463);
        set_req(5, 0, 0, 0, 0);
        step();
        chk_write("seq_halt", 8, 32'h0000007F);
        chk("seq_halt_done", done, 1);
        chk("seq_halt_ready", req_ready, 0);
        set_req(0, 3, 1, 2, 0);
        step();
        req_valid = 1'b0;
        chk("after_halt_wr_en", wr_en, 0);
        chk("after_halt_done", done, 1);
        chk("after_halt_count", count, 3);
        chk("after_halt_err_full", err_full, 0);

        // illegal op between two ADDs
        do_start();
        chk("restart_done", done, 0);
        set_req(0, 3, 1, 2, 0); req_valid = 1'b1;
        step();
        chk_write("ill_add0", 0, 32'h002081B3);
        set_req(6, 3, 1, 2, 0);
        step();
        chk("ill_wr_en", wr_en, 0);
        chk("ill_err", err_illegal, 1);
        chk("ill_count", count, 1);
        chk("ill_ready", req_ready, 1);
        set_req(0, 3, 1, 2, 0);
        step();
        chk_write("ill_add1", 4, 32'h002081B3);
        chk("ill_sticky", err_illegal, 1);

        // start during RUN drops the same-cycle handshake
        start = 1'b1;
        step();
        start = 1'b0;
        chk("srun_wr_en", wr_en, 0);
        chk("srun_count", count, 0);
        chk("srun_err_clr", err_illegal, 0);
        step();
        req_valid = 1'b0;
        chk_write("srun_add", 0, 32'h002081B3);

        // small memory fills without HALT
        set_req(0, 3, 1, 2, 0);
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_op = 3'd0; s_valid = 1'b1;
        nw = 0; last_a = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_wr_en) begin
                nw++;
                last_a = int'(s_wr_addr);
                chk("full_data", s_wr_data, 32'h002081B3);
            end
        end
        s_valid = 1'b0;
        chk("full_writes", nw, 4);
        chk("full_last_addr", last_a, 'hC);
        chk("full_err_full", s_err_full, 1);
        chk("full_done", s_done, 1);
        chk("full_count", s_count, 4);
        chk("full_ready", s_ready, 0);

        // reset right after a handshake
        do_start();
        set_req(0, 3, 1, 2, 0); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("mid_pre_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_wr_en", wr_en, 0);
        chk("mid_wr_addr", wr_addr, 0);
        chk("mid_wr_data", wr_data, 0);
        chk("mid_count", count, 0);
        chk("mid_ready", req_ready, 0);
        chk("mid_done", done, 0);
        #2 rst_n = 1'b1;
        step();
        do_start();
        set_req(0, 3, 1, 2, 0); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk_write("mid_after", 0, 32'h002081B3);
        chk("mid_after_count", count, 1);

        // randomized traffic against the reference model
        do_start();
        m_addr = 0; m_count = 0; m_run = 1; m_ill = 0; m_full = 0;
        for (int it = 0; it < 1500; it++) begin
            int r, op;
            r = $urandom_range(0, 15);
            op = r < 12 ? r % 5 : (r < 14 ? 6 + r % 2 : 5);
            set_req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 13'($urandom));
            req_valid = $urandom_range(0, 3) != 0;
            chk("rnd_ready", req_ready, m_run);
            exp_we = 0; exp_a = 0; exp_d = 0;
            if (req_valid && m_run) begin
                if (op > 5) m_ill = 1;
                else begin
                    exp_we = 1; exp_a = m_addr;
                    exp_d = ref_enc(op, req_rd, req_rs1, req_rs2, int'(req_imm));
                    m_count++;
                    if (op == 5) m_run = 0;
                    else if (m_addr == 4 * 255) begin m_run = 0; m_full = 1; end
                    else m_addr += 4;
                end
            end
            step();
            chk("rnd_wr_en", wr_en, exp_we);
            if (exp_we) begin
                chk("rnd_addr", wr_addr, exp_a);
                chk("rnd_data", wr_data, exp_d);
            end
            chk("rnd_count", count, m_count);
            chk("rnd_done", done, !m_run);
            chk("rnd_err_illegal", err_illegal, m_ill);
            chk("rnd_err_full", err_full, m_full);
            if (!m_run) begin
                do_start();
                m_addr = 0; m_count = 0; m_run = 1; m_ill = 0; m_full = 0;
            end
        end
        req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
